// File: rtl/mul_div_row_sequencer_if.sv
// Request/result bundle for the iterative multiply/divide row sequencer.
// The master side issues operations; the slave side is the sequencer itself.
interface mul_div_row_sequencer_if #(parameter int W = 4);
  logic            i_start;
  logic            i_mul_bar;
  logic [W-1:0]    i_a;
  logic [2*W-1:0]  i_b;
  logic            o_busy;
  logic            o_done;
  logic [W-1:0]    o_result_hi;
  logic [W-1:0]    o_result_lo;
  logic            o_div_err;
  logic            o_ovf;

  modport master (
    output i_start, i_mul_bar, i_a, i_b,
    input  o_busy, o_done, o_result_hi, o_result_lo, o_div_err, o_ovf
  );

  modport slave (
    input  i_start, i_mul_bar, i_a, i_b,
    output o_busy, o_done, o_result_hi, o_result_lo, o_div_err, o_ovf
  );
endinterface

// File: rtl/mul_div_row_sequencer.sv
// Iterative unsigned multiply (shift-add) / divide (non-restoring) unit that reuses
// a single W+1-bit add/sub row for W cycles, with a final remainder correction step.
module mul_div_row_sequencer #(
  parameter int W = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  mul_div_row_sequencer_if.slave    bus
);
  localparam int STEP_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic [STEP_W-1:0] r_step;
  logic              r_mulBar;
  logic [W-1:0]      r_a;
  logic [W:0]        r_acc;
  logic [W-1:0]      r_q;
  logic              r_p;
  logic              r_errDiv;
  logic              r_errOvf;
  logic              r_busy;
  logic              r_done;
  logic [W-1:0]      r_resHi;
  logic [W-1:0]      r_resLo;
  logic              r_outDivErr;
  logic              r_outOvf;

  logic [W:0] w_aExt;
  logic [W:0] w_mulSum;
  logic [W:0] w_divShift;
  logic [W:0] w_divSum;
  logic [W:0] w_fixR;
  logic       w_lastStep;

  // r_acc doubles as the multiply accumulator and the signed partial remainder R.
  assign w_aExt     = {1'b0, r_a};
  assign w_mulSum   = r_q[0] ? (r_acc + w_aExt) : r_acc;
  assign w_divShift = {r_acc[W-1:0], r_q[W-1]};
  assign w_divSum   = r_p ? (w_divShift + w_aExt) : (w_divShift - w_aExt);
  assign w_fixR     = r_acc[W] ? (r_acc + w_aExt) : r_acc;
  assign w_lastStep = (r_step == STEP_W'(W - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_mulBar    <= 1'b0;
      r_a         <= '0;
      r_acc       <= '0;
      r_q         <= '0;
      r_p         <= 1'b0;
      r_errDiv    <= 1'b0;
      r_errOvf    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_resHi     <= '0;
      r_resLo     <= '0;
      r_outDivErr <= 1'b0;
      r_outOvf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_mulBar <= bus.i_mul_bar;
            r_a      <= bus.i_a;
            r_acc    <= bus.i_mul_bar ? {1'b0, bus.i_b[2*W-1:W]} : '0;
            r_q      <= bus.i_b[W-1:0];
            r_busy   <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_outDivErr <= 1'b0;
          r_outOvf    <= 1'b0;
          r_p         <= 1'b0;
          r_step      <= '0;
          r_errDiv    <= r_mulBar && (r_a == '0);
          r_errOvf    <= r_mulBar && (r_a != '0) && (r_acc[W-1:0] >= r_a);
          // Errors still pass through FIX so they share its single settle cycle.
          if (r_mulBar && ((r_a == '0) || (r_acc[W-1:0] >= r_a)))
            r_state <= S_FIX;
          else
            r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_mulBar) begin
            r_acc <= w_divSum;
            r_q   <= {r_q[W-2:0], ~w_divSum[W]};
            r_p   <= w_divSum[W];
          end else begin
            r_acc <= {1'b0, w_mulSum[W:1]};
            r_q   <= {w_mulSum[0], r_q[W-1:1]};
          end
          if (w_lastStep) begin
            r_step <= '0;
            if (r_mulBar) begin
              r_state <= S_FIX;
            end else begin
              r_resHi <= w_mulSum[W:1];
              r_resLo <= {w_mulSum[0], r_q[W-1:1]};
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_step <= r_step + STEP_W'(1);
          end
        end
        S_FIX: begin
          if (r_errDiv || r_errOvf) begin
            r_resHi     <= '1;
            r_resLo     <= '1;
            r_outDivErr <= r_errDiv;
            r_outOvf    <= r_errOvf;
          end else begin
            r_resHi <= w_fixR[W-1:0];
            r_resLo <= r_q;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_result_hi = r_resHi;
  assign bus.o_result_lo = r_resLo;
  assign bus.o_div_err   = r_outDivErr;
  assign bus.o_ovf       = r_outOvf;
endmodule

// File: tb/tb_mul_div_row_sequencer.sv
// Directed bench for mul_div_row_sequencer (W=4) with hand-computed expected results.
module tb_mul_div_row_sequencer;
  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  mul_div_row_sequencer_if #(.W(4)) bus ();

  mul_div_row_sequencer #(.W(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation and waits (bounded) for DONE, sampling on falling edges.
  task automatic runOp(input logic mb, input logic [3:0] a, input logic [7:0] b,
                       output int lat, output int busyCnt);
    bit finished;
    @(negedge clk);
    bus.i_start   = 1'b1;
    bus.i_mul_bar = mb;
    bus.i_a       = a;
    bus.i_b       = b;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    lat = 0;
    busyCnt = 0;
    finished = 1'b0;
    while (!finished) begin
      @(negedge clk);
      if (bus.o_busy === 1'b1) busyCnt++;
      if (bus.o_done === 1'b1 || lat >= 20) finished = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_mul_bar = 1'b0; bus.i_a = '0; bus.i_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    testsRun++; if (bus.o_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %0b expected 0", bus.o_busy); end
    testsRun++; if (bus.o_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done got %0b expected 0", bus.o_done); end
    testsRun++; if (bus.o_result_hi !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_hi got %0h expected 0", bus.o_result_hi); end
    testsRun++; if (bus.o_result_lo !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_lo got %0h expected 0", bus.o_result_lo); end
    testsRun++; if ({bus.o_div_err, bus.o_ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_flags got %b expected 00", {bus.o_div_err, bus.o_ovf}); end
    rst = 1'b0;
  endtask

  task automatic test_multiply;
    int lat, busyCnt;
    runOp(1'b0, 4'd13, 8'd11, lat, busyCnt);
    testsRun++; if (lat !== 5) begin testsFailed++; $display("[TB] FAIL mul_latency got %0d expected 5", lat); end
    testsRun++; if (busyCnt !== 5) begin testsFailed++; $display("[TB] FAIL mul_busy_cycles got %0d expected 5", busyCnt); end
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'h8F) begin testsFailed++; $display("[TB] FAIL mul_13x11 got %h expected 8f", {bus.o_result_hi, bus.o_result_lo}); end
    testsRun++; if ({bus.o_div_err, bus.o_ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL mul_flags got %b expected 00", {bus.o_div_err, bus.o_ovf}); end
    @(negedge clk);
    testsRun++; if (bus.o_done !== 1'b0) begin testsFailed++; $display("[TB] FAIL mul_done_pulse got %0b expected 0", bus.o_done); end
    repeat (3) @(negedge clk);
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'h8F) begin testsFailed++; $display("[TB] FAIL mul_hold got %h expected 8f", {bus.o_result_hi, bus.o_result_lo}); end
    runOp(1'b0, 4'd15, 8'd15, lat, busyCnt);
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'hE1) begin testsFailed++; $display("[TB] FAIL mul_15x15 got %h expected e1", {bus.o_result_hi, bus.o_result_lo}); end
    runOp(1'b0, 4'd0, 8'd9, lat, busyCnt);
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'h00) begin testsFailed++; $display("[TB] FAIL mul_0x9 got %h expected 00", {bus.o_result_hi, bus.o_result_lo}); end
    runOp(1'b0, 4'd3, 8'hA9, lat, busyCnt);
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'h1B) begin testsFailed++; $display("[TB] FAIL mul_upper_b_ignored got %h expected 1b", {bus.o_result_hi, bus.o_result_lo}); end
  endtask

  task automatic test_divide;
    int lat, busyCnt;
    runOp(1'b1, 4'd7, 8'd100, lat, busyCnt);
    testsRun++; if (lat !== 6) begin testsFailed++; $display("[TB] FAIL div_latency got %0d expected 6", lat); end
    testsRun++; if (busyCnt !== 6) begin testsFailed++; $display("[TB] FAIL div_busy_cycles got %0d expected 6", busyCnt); end
    testsRun++; if (bus.o_result_lo !== 4'd14) begin testsFailed++; $display("[TB] FAIL div_100_7_quot got %0d expected 14", bus.o_result_lo); end
    testsRun++; if (bus.o_result_hi !== 4'd2) begin testsFailed++; $display("[TB] FAIL div_100_7_rem got %0d expected 2", bus.o_result_hi); end
    testsRun++; if ({bus.o_div_err, bus.o_ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL div_flags got %b expected 00", {bus.o_div_err, bus.o_ovf}); end
    runOp(1'b1, 4'd15, 8'd225, lat, busyCnt);
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'h0F) begin testsFailed++; $display("[TB] FAIL div_225_15 got %h expected 0f", {bus.o_result_hi, bus.o_result_lo}); end
    runOp(1'b1, 4'd3, 8'd11, lat, busyCnt);
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'h23) begin testsFailed++; $display("[TB] FAIL div_11_3 got %h expected 23", {bus.o_result_hi, bus.o_result_lo}); end
  endtask

  task automatic test_errors;
    int lat, busyCnt;
    runOp(1'b1, 4'd0, 8'd5, lat, busyCnt);
    testsRun++; if (lat !== 2) begin testsFailed++; $display("[TB] FAIL dz_latency got %0d expected 2", lat); end
    testsRun++; if ({bus.o_div_err, bus.o_ovf} !== 2'b10) begin testsFailed++; $display("[TB] FAIL dz_flags got %b expected 10", {bus.o_div_err, bus.o_ovf}); end
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'hFF) begin testsFailed++; $display("[TB] FAIL dz_result got %h expected ff", {bus.o_result_hi, bus.o_result_lo}); end
    runOp(1'b1, 4'd7, 8'h70, lat, busyCnt);
    testsRun++; if (lat !== 2) begin testsFailed++; $display("[TB] FAIL ovf_latency got %0d expected 2", lat); end
    testsRun++; if ({bus.o_div_err, bus.o_ovf} !== 2'b01) begin testsFailed++; $display("[TB] FAIL ovf_flags got %b expected 01", {bus.o_div_err, bus.o_ovf}); end
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'hFF) begin testsFailed++; $display("[TB] FAIL ovf_result got %h expected ff", {bus.o_result_hi, bus.o_result_lo}); end
    runOp(1'b1, 4'd7, 8'h6F, lat, busyCnt);
    testsRun++; if ({bus.o_div_err, bus.o_ovf} !== 2'b00) begin testsFailed++; $display("[TB] FAIL ovf_edge_flags got %b expected 00", {bus.o_div_err, bus.o_ovf}); end
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'h6F) begin testsFailed++; $display("[TB] FAIL ovf_edge_result got %h expected 6f", {bus.o_result_hi, bus.o_result_lo}); end
  endtask

  task automatic test_ignore_start;
    int lat;
    bit finished;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_mul_bar = 1'b0; bus.i_a = 4'd13; bus.i_b = 8'd11;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    lat = 0;
    finished = 1'b0;
    while (!finished) begin
      @(negedge clk);
      if (lat == 2) begin
        bus.i_start = 1'b1; bus.i_mul_bar = 1'b1; bus.i_a = 4'd3; bus.i_b = 8'hFF;
      end else if (lat == 4) begin
        bus.i_start = 1'b0;
      end
      if (bus.o_done === 1'b1 || lat >= 20) finished = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    bus.i_start = 1'b0;
    testsRun++; if (lat !== 5) begin testsFailed++; $display("[TB] FAIL ignore_latency got %0d expected 5", lat); end
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo, bus.o_div_err} !== 9'h11E) begin testsFailed++; $display("[TB] FAIL ignore_result got %h expected 11e", {bus.o_result_hi, bus.o_result_lo, bus.o_div_err}); end
    @(negedge clk);
    @(negedge clk);
    testsRun++; if (bus.o_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL ignore_no_queue got %0b expected 0", bus.o_busy); end
  endtask

  task automatic test_reset_mid_run;
    int lat, busyCnt;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_mul_bar = 1'b1; bus.i_a = 4'd7; bus.i_b = 8'd100;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    testsRun++; if ({bus.o_busy, bus.o_done, bus.o_div_err, bus.o_ovf} !== 4'b0000) begin testsFailed++; $display("[TB] FAIL midrst_ctrl got %b expected 0000", {bus.o_busy, bus.o_done, bus.o_div_err, bus.o_ovf}); end
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'h00) begin testsFailed++; $display("[TB] FAIL midrst_result got %h expected 00", {bus.o_result_hi, bus.o_result_lo}); end
    rst = 1'b0;
    runOp(1'b1, 4'd7, 8'd100, lat, busyCnt);
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'h2E) begin testsFailed++; $display("[TB] FAIL midrst_next_div got %h expected 2e", {bus.o_result_hi, bus.o_result_lo}); end
    testsRun++; if (lat !== 6) begin testsFailed++; $display("[TB] FAIL midrst_next_latency got %0d expected 6", lat); end
  endtask

  task automatic test_back_to_back;
    int lat, busyCnt;
    runOp(1'b1, 4'd0, 8'd1, lat, busyCnt);
    runOp(1'b0, 4'd5, 8'd6, lat, busyCnt);
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo, bus.o_div_err} !== 9'h03C) begin testsFailed++; $display("[TB] FAIL b2b_mul_after_err got %h expected 03c", {bus.o_result_hi, bus.o_result_lo, bus.o_div_err}); end
    runOp(1'b1, 4'd9, 8'd80, lat, busyCnt);
    testsRun++; if ({bus.o_result_hi, bus.o_result_lo} !== 8'h88) begin testsFailed++; $display("[TB] FAIL b2b_div_80_9 got %h expected 88", {bus.o_result_hi, bus.o_result_lo}); end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset;
    test_multiply;
    test_divide;
    test_errors;
    test_ignore_start;
    test_reset_mid_run;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
